// File: rtl/fp_serial_frontend.sv
// rtl/fp_serial_frontend.sv - byte-serial command/result front end for the FP ALU datapath
//
// Purpose: assembles a 9-byte command frame (opcode, A, B), drives the FP unit
// operands and a one-cycle op_start pulse, captures op_result after OP_LATENCY
// cycles and streams it back MSB first as 4 bytes over a valid/ready link.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_data/valid/ready    command byte stream
//   op_a, op_b, op_sel     operands and operation select to the FP unit
//   op_start               one-cycle pulse, operands valid
//   op_result              FP unit result
//   out_data/valid/ready   result byte stream
//   busy                   frame in progress
module fp_serial_frontend #(
    parameter int OP_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic [1:0]  op_sel,
    output logic        op_start,
    input  logic [31:0] op_result,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_RX   = 2'd0,
        S_EXEC = 2'd1,
        S_SEND = 2'd2
    } state_t;

    localparam logic [3:0] LAT = 4'(OP_LATENCY);

    state_t      state;
    logic [3:0]  rx_cnt;
    logic [1:0]  tx_cnt;
    logic [3:0]  wait_cnt;
    logic [31:0] result;

    function automatic logic [7:0] res_byte(input logic [31:0] r, input logic [1:0] idx);
        case (idx)
            2'd0:    res_byte = r[31:24];
            2'd1:    res_byte = r[23:16];
            2'd2:    res_byte = r[15:8];
            default: res_byte = r[7:0];
        endcase
    endfunction

    // in_ready is combinational so the host sees it drop while rst is held.
    assign in_ready = (state == S_RX) & ~rst;
    assign busy     = (state != S_RX) | (rx_cnt != 4'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_RX;
            rx_cnt    <= 4'd0;
            tx_cnt    <= 2'd0;
            wait_cnt  <= 4'd0;
            result    <= 32'd0;
            op_a      <= 32'd0;
            op_b      <= 32'd0;
            op_sel    <= 2'd0;
            op_start  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= 8'd0;
        end else begin
            op_start <= 1'b0;
            case (state)
                S_RX: begin
                    if (in_valid) begin
                        if (rx_cnt == 4'd0)
                            op_sel <= in_data[1:0];
                        else if (rx_cnt <= 4'd4)
                            op_a <= {op_a[23:0], in_data};
                        else
                            op_b <= {op_b[23:0], in_data};

                        if (rx_cnt == 4'd8) begin
                            rx_cnt   <= 4'd0;
                            wait_cnt <= 4'd0;
                            op_start <= 1'b1;
                            state    <= S_EXEC;
                        end else begin
                            rx_cnt <= rx_cnt + 4'd1;
                        end
                    end
                end
                S_EXEC: begin
                    // Operands stay frozen here; only RX accepts modify them.
                    if (wait_cnt == LAT) begin
                        result    <= op_result;
                        out_data  <= op_result[31:24];
                        out_valid <= 1'b1;
                        tx_cnt    <= 2'd0;
                        state     <= S_SEND;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                S_SEND: begin
                    if (out_ready) begin
                        if (tx_cnt == 2'd3) begin
                            out_valid <= 1'b0;
                            state     <= S_RX;
                        end else begin
                            tx_cnt   <= tx_cnt + 2'd1;
                            out_data <= res_byte(result, tx_cnt + 2'd1);
                        end
                    end
                end
                default: state <= S_RX;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_serial_frontend.sv
// tb/tb_fp_serial_frontend.sv - directed self-checking bench for fp_serial_frontend
module tb_fp_serial_frontend;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // OP_LATENCY=1 instance
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] op_a, op_b, op_result;
    logic [1:0]  op_sel;
    logic        op_start;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        busy;

    // OP_LATENCY=0 instance
    logic [7:0]  z_in_data = 8'd0;
    logic        z_in_valid = 1'b0;
    logic        z_in_ready;
    logic [31:0] z_op_a, z_op_b, z_op_result;
    logic [1:0]  z_op_sel;
    logic        z_op_start;
    logic [7:0]  z_out_data;
    logic        z_out_valid;
    logic        z_out_ready = 1'b1;
    logic        z_busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int acc_cnt = 0, last_acc = 0, start_cnt = 0, start_cyc = 0;
    logic [7:0] rxq[$];
    int z_acc_cyc[$], z_start_q[$], z_out_cyc[$];
    logic [7:0] z_rxq[$];

    fp_serial_frontend #(.OP_LATENCY(1)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .op_sel(op_sel), .op_start(op_start), .op_result(op_result),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    fp_serial_frontend #(.OP_LATENCY(0)) dut_z (
        .clk(clk), .rst(rst), .in_data(z_in_data), .in_valid(z_in_valid), .in_ready(z_in_ready),
        .op_a(z_op_a), .op_b(z_op_b), .op_sel(z_op_sel), .op_start(z_op_start), .op_result(z_op_result),
        .out_data(z_out_data), .out_valid(z_out_valid), .out_ready(z_out_ready), .busy(z_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] fp_model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] s);
        if (s == 2'd0 && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        if (s == 2'd1 && a == 32'h40400000 && b == 32'h3F800000) return 32'h40000000;
        return a ^ b ^ {30'd0, s};
    endfunction

    // One-stage FP unit: result is valid only in the cycle after op_start.
    logic [31:0] res_q = 32'hBAD0BAD0;
    always @(posedge clk) res_q <= op_start ? fp_model(op_a, op_b, op_sel) : 32'hBAD0BAD0;
    assign op_result = res_q;

    // Combinational FP unit: result is valid only while op_start is high.
    assign z_op_result = z_op_start ? fp_model(z_op_a, z_op_b, z_op_sel) : 32'hDEADBEEF;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready) begin
                acc_cnt  <= acc_cnt + 1;
                last_acc <= cyc;
            end
            if (op_start) begin
                start_cnt <= start_cnt + 1;
                start_cyc <= cyc;
            end
            if (out_valid && out_ready) rxq.push_back(out_data);
            if (z_in_valid && z_in_ready) z_acc_cyc.push_back(cyc);
            if (z_op_start) z_start_q.push_back(cyc);
            if (z_out_valid && z_out_ready) begin
                z_rxq.push_back(z_out_data);
                z_out_cyc.push_back(cyc);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called right after a posedge (+1); returns at the same phase after the accept edge.
    task automatic send_byte(input logic [7:0] b, input bit hold);
        bit ok;
        in_valid = 1'b1;
        in_data  = b;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) break;
            if (n == 199) check("send_timeout", 32'd1, 32'd0);
        end
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                              input int max_gap, input bit hold_last);
        logic [7:0] fr[9];
        fr[0] = op;
        for (int i = 0; i < 4; i++) begin
            fr[1+i] = a[31-8*i -: 8];
            fr[5+i] = b[31-8*i -: 8];
        end
        for (int i = 0; i < 9; i++) begin
            if (max_gap > 0) repeat ($urandom_range(0, max_gap)) begin
                @(posedge clk);
                #1;
            end
            send_byte(fr[i], (i == 8) ? hold_last : 1'b0);
        end
    endtask

    task automatic wait_bytes(input int n);
        for (int i = 0; i < 200; i++) begin
            if (rxq.size() >= n) break;
            @(posedge clk);
        end
        #1;
        check("result_bytes_arrived", 32'(rxq.size() >= n), 32'd1);
    endtask

    task automatic check_result(input string tag, input logic [31:0] exp);
        check({tag, "_count"}, 32'(rxq.size()), 32'd4);
        for (int i = 0; i < 4 && i < rxq.size(); i++)
            check({tag, "_byte"}, {24'd0, rxq[i]}, {24'd0, exp[31-8*i -: 8]});
        rxq.delete();
    endtask

    int s0, a0, bad, zi;

    initial begin
        // 1. reset
        @(negedge clk);
        check("rst_in_ready_low", {31'd0, in_ready}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_op_start", {31'd0, op_start}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_op_a", op_a, 32'd0);
        check("rst_op_b", op_b, 32'd0);
        @(posedge clk);
        #1;

        // 2. add frame, latency 1
        s0 = start_cnt;
        send_frame(8'h00, 32'h3F800000, 32'h40000000, 0, 1'b0);
        wait_bytes(4);
        check("t2_start_count", 32'(start_cnt - s0), 32'd1);
        check("t2_start_latency", 32'(start_cyc - last_acc), 32'd1);
        check("t2_op_a", op_a, 32'h3F800000);
        check("t2_op_b", op_b, 32'h40000000);
        check("t2_op_sel", {30'd0, op_sel}, 32'd0);
        check_result("t2_res", 32'h40400000);

        // 3. sub frame with output stall on byte 2
        send_frame(8'h01, 32'h40400000, 32'h3F800000, 0, 1'b0);
        check("t3_op_sel", {30'd0, op_sel}, 32'd1);
        for (int i = 0; i < 200; i++) begin
            if (rxq.size() >= 2) break;
            @(posedge clk);
        end
        #1 out_ready = 1'b0;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (!(out_valid === 1'b1 && out_data === 8'h00)) bad++;
        end
        check("t3_stall_hold", 32'(bad), 32'd0);
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_bytes(4);
        repeat (5) @(posedge clk);
        #1 check_result("t3_res", 32'h40000000);

        // 4. opcode FD, random gaps, in_valid held through EXEC/SEND
        a0 = acc_cnt;
        send_frame(8'hFD, 32'h40400000, 32'h3F800000, 3, 1'b1);
        in_data = 8'hEE;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) bad++;
            @(posedge clk);
            if (rxq.size() >= 4) break;
        end
        #1 in_valid = 1'b0;
        check("t4_in_ready_low", 32'(bad), 32'd0);
        check("t4_op_sel", {30'd0, op_sel}, 32'd1);
        repeat (3) @(posedge clk);
        #1 check("t4_accepts", 32'(acc_cnt - a0), 32'd9);
        check_result("t4_res", 32'h40000000);

        // 5. reset mid-frame, then a clean frame
        send_byte(8'h01, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        check("t5_busy_mid", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        s0 = start_cnt;
        send_frame(8'h00, 32'h3F800000, 32'h40000000, 0, 1'b0);
        check("t5_op_a", op_a, 32'h3F800000);
        check("t5_op_b", op_b, 32'h40000000);
        check("t5_op_sel", {30'd0, op_sel}, 32'd0);
        wait_bytes(4);
        repeat (10) @(posedge clk);
        #1 check("t5_start_count", 32'(start_cnt - s0), 32'd1);
        check_result("t5_res", 32'h40400000);

        // 6. OP_LATENCY=0, two back-to-back frames, in_valid held high
        begin
            logic [7:0] zb[18];
            zb = '{8'h00, 8'h3F, 8'h80, 8'h00, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00,
                   8'h01, 8'h40, 8'h40, 8'h00, 8'h00, 8'h3F, 8'h80, 8'h00, 8'h00};
            z_in_valid = 1'b1;
            zi = 0;
            for (int n = 0; n < 400 && zi < 18; n++) begin
                z_in_data = zb[zi];
                @(negedge clk);
                if (z_in_ready) zi++;
                @(posedge clk);
                #1;
            end
            z_in_valid = 1'b0;
            check("t6_all_sent", 32'(zi), 32'd18);
        end
        for (int i = 0; i < 200; i++) begin
            if (z_rxq.size() >= 8) break;
            @(posedge clk);
        end
        #1;
        check("t6_byte_count", 32'(z_rxq.size()), 32'd8);
        if (z_rxq.size() >= 8 && z_acc_cyc.size() >= 10 && z_start_q.size() >= 1) begin
            check("t6_r0", {z_rxq[0], z_rxq[1], z_rxq[2], z_rxq[3]}, 32'h40400000);
            check("t6_r1", {z_rxq[4], z_rxq[5], z_rxq[6], z_rxq[7]}, 32'h40000000);
            check("t6_start_latency", 32'(z_start_q[0] - z_acc_cyc[8]), 32'd1);
            check("t6_first_out", 32'(z_out_cyc[0] - z_start_q[0]), 32'd1);
            check("t6_turnaround", 32'(z_acc_cyc[9] - z_out_cyc[3]), 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
